// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Shared immediate-select encodings and raw field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

  localparam logic [2:0] IMM_U       = 3'b000;
  localparam logic [2:0] IMM_J       = 3'b001;
  localparam logic [2:0] IMM_I       = 3'b010;
  localparam logic [2:0] IMM_S       = 3'b011;
  localparam logic [2:0] IMM_B       = 3'b100;
  localparam logic [2:0] IMM_SHAMT   = 3'b101;
  localparam logic [2:0] IMM_ZIMM    = 3'b110;
  localparam logic [2:0] IMM_ILLEGAL = 3'b111;

  localparam int ZEXT_BIT = 3;

  localparam int RAW_W_U = 20;
  localparam int RAW_W_J = 21;
  localparam int RAW_W_I = 12;
  localparam int RAW_W_S = 12;
  localparam int RAW_W_B = 13;

endpackage
`default_nettype wire

// File: rtl/imm_extract.sv
`default_nettype none
// ============================================================================
// Module      : imm_extract
// Description : Combinational immediate extraction and XLEN extension.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     INSTRUCTION,
  input  logic [3:0]      SELECT,
  output logic [XLEN-1:0] IMM,
  output logic            ERR
);

  logic        w_fill;
  logic        w_hi_fill;
  logic [5:0]  w_shamt;
  logic [31:0] w_imm32;
  logic        w_unused_opcode;

  assign w_unused_opcode = ^INSTRUCTION[6:0];

  generate
    if (XLEN == 64) begin : g_shamt64
      assign w_shamt = INSTRUCTION[25:20];
    end else if (XLEN == 32) begin : g_shamt32
      assign w_shamt = {1'b0, INSTRUCTION[24:20]};
    end else begin : g_bad_xlen
      $fatal(1, "imm_extract: XLEN must be 32 or 64");
    end
  endgenerate

  always_comb begin
    w_fill    = ~SELECT[ZEXT_BIT] & INSTRUCTION[31];
    w_hi_fill = 1'b0;
    w_imm32   = '0;
    ERR       = 1'b0;
    case (SELECT[2:0])
      IMM_U: begin
        w_imm32   = {INSTRUCTION[31:12], {(32-RAW_W_U){1'b0}}};
        w_hi_fill = w_fill;
      end
      IMM_J: begin
        w_imm32   = {{(32-RAW_W_J){w_fill}}, INSTRUCTION[31], INSTRUCTION[19:12],
                     INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};
        w_hi_fill = w_fill;
      end
      IMM_I: begin
        w_imm32   = {{(32-RAW_W_I){w_fill}}, INSTRUCTION[31:20]};
        w_hi_fill = w_fill;
      end
      IMM_S: begin
        w_imm32   = {{(32-RAW_W_S){w_fill}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
        w_hi_fill = w_fill;
      end
      IMM_B: begin
        w_imm32   = {{(32-RAW_W_B){w_fill}}, INSTRUCTION[31], INSTRUCTION[7],
                     INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
        w_hi_fill = w_fill;
      end
      // Shift amounts and CSR immediates are unsigned regardless of SELECT[3]
      IMM_SHAMT: w_imm32 = {26'b0, w_shamt};
      IMM_ZIMM:  w_imm32 = {27'b0, INSTRUCTION[19:15]};
      default:   ERR     = 1'b1;
    endcase
  end

  generate
    if (XLEN == 64) begin : g_out64
      assign IMM = {{32{w_hi_fill}}, w_imm32};
    end else begin : g_out32
      logic w_unused_fill;
      assign w_unused_fill = w_hi_fill;
      assign IMM = w_imm32[XLEN-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Registered immediate generator with 2-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      INSTRUCTION,
  input  logic [3:0]       SELECT,
  input  logic [TAG_W-1:0] IN_TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  OUT_IMM,
  output logic [TAG_W-1:0] OUT_TAG,
  output logic             OUT_ERR
);

  logic [XLEN-1:0]  w_imm;
  logic             w_err;
  logic             w_accept;
  logic             w_out_free;

  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_imm;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_err;
  logic             r_skid_valid;
  logic [XLEN-1:0]  r_skid_imm;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_skid_err;

  imm_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .INSTRUCTION (INSTRUCTION),
    .SELECT      (SELECT),
    .IMM         (w_imm),
    .ERR         (w_err)
  );

  assign IN_READY   = ~r_skid_valid;
  assign w_accept   = IN_VALID & IN_READY;
  assign w_out_free = ~r_out_valid | OUT_READY;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_out_valid  <= 1'b0;
      r_out_imm    <= '0;
      r_out_tag    <= '0;
      r_out_err    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_tag   <= '0;
      r_skid_err   <= 1'b0;
    end else if (FLUSH) begin
      // Data registers keep their contents; only occupancy is cleared
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_imm    <= r_skid_imm;
        r_out_tag    <= r_skid_tag;
        r_out_err    <= r_skid_err;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_accept;
        if (w_accept) begin
          r_out_imm <= w_imm;
          r_out_tag <= IN_TAG;
          r_out_err <= w_err;
        end
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_imm   <= w_imm;
      r_skid_tag   <= IN_TAG;
      r_skid_err   <= w_err;
    end
  end

  assign OUT_VALID = r_out_valid;
  assign OUT_IMM   = r_out_imm;
  assign OUT_TAG   = r_out_tag;
  assign OUT_ERR   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Scoreboard bench driving XLEN=32 and XLEN=64 builds in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] e32;
    logic [63:0] e64;
    logic [7:0]  tag;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic [3:0]  sel;
  logic [7:0]  in_tag;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32;
  logic [7:0]  out_tag32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
  logic [7:0]  out_tag64;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t pend;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
    .CLK(clk), .RESET(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready32),
    .INSTRUCTION(inst), .SELECT(sel), .IN_TAG(in_tag), .OUT_VALID(out_valid32),
    .OUT_READY(out_ready), .OUT_IMM(out_imm32), .OUT_TAG(out_tag32), .OUT_ERR(out_err32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .CLK(clk), .RESET(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready64),
    .INSTRUCTION(inst), .SELECT(sel), .IN_TAG(in_tag), .OUT_VALID(out_valid64),
    .OUT_READY(out_ready), .OUT_IMM(out_imm64), .OUT_TAG(out_tag64), .OUT_ERR(out_err64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference extraction: raw field plus its width, then generic sign fill
  task automatic model(input logic [31:0] i, input logic [3:0] s,
                       output logic [63:0] e32, output logic [63:0] e64, output logic e);
    logic [63:0] raw;
    int          w;
    e   = 1'b0;
    raw = '0;
    w   = 1;
    case (s[2:0])
      3'd0: begin raw = {32'b0, i[31:12], 12'b0}; w = 32; end
      3'd1: begin raw = 64'({i[31], i[19:12], i[20], i[30:21], 1'b0}); w = 21; end
      3'd2: begin raw = 64'(i[31:20]); w = 12; end
      3'd3: begin raw = 64'({i[31:25], i[11:7]}); w = 12; end
      3'd4: begin raw = 64'({i[31], i[7], i[30:25], i[11:8], 1'b0}); w = 13; end
      default: ;
    endcase
    if (!s[3] && raw[w-1]) raw = raw | (~64'd0 << w);
    e64 = raw;
    e32 = {32'b0, raw[31:0]};
    if (s[2:0] == 3'd5) begin e64 = 64'(i[25:20]); e32 = 64'(i[24:20]); end
    if (s[2:0] == 3'd6) begin e64 = 64'(i[19:15]); e32 = 64'(i[19:15]); end
    if (s[2:0] == 3'd7) begin e64 = '0; e32 = '0; e = 1'b1; end
  endtask

  task automatic check_state();
    check("in_ready32",  64'(in_ready32),  64'(q.size() < 2));
    check("in_ready64",  64'(in_ready64),  64'(q.size() < 2));
    check("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
    check("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check("imm32", {32'b0, out_imm32}, q[0].e32);
      check("imm64", out_imm64,          q[0].e64);
      check("tag32", 64'(out_tag32),     64'(q[0].tag));
      check("tag64", 64'(out_tag64),     64'(q[0].tag));
      check("err32", 64'(out_err32),     64'(q[0].err));
      check("err64", 64'(out_err64),     64'(q[0].err));
    end
  endtask

  task automatic cycle(output bit acc);
    bit cons;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    acc  = in_valid && in_ready32;
    cons = out_valid32 && out_ready;
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
    end else begin
      if (cons && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(pend);
    end
    check_state();
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    repeat (n) cycle(acc);
  endtask

  task automatic send(input logic [31:0] i, input logic [3:0] s, input logic [7:0] t,
                      input logic [63:0] e32, input logic [63:0] e64, input logic e);
    bit acc;
    int n;
    inst     = i;
    sel      = s;
    in_tag   = t;
    in_valid = 1'b1;
    pend     = '{e32: e32, e64: e64, tag: t, err: e};
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 50) begin
      cycle(acc);
      n++;
    end
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] ri;
    logic [3:0]  rs;
    logic [63:0] m32, m64;
    logic        me;
    bit          acc;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    inst = '0; sel = '0; in_tag = '0; pend = '0;
    #12;
    check("rst_out_valid32", 64'(out_valid32), 64'd0);
    check("rst_out_valid64", 64'(out_valid64), 64'd0);
    check("rst_in_ready32",  64'(in_ready32),  64'd1);
    check("rst_imm64",       out_imm64,        64'd0);
    check("rst_tag32",       64'(out_tag32),   64'd0);
    check("rst_err64",       64'(out_err64),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors streamed back to back with the consumer always ready
    send(32'hFFF00093, 4'b0010, 8'd1,  64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    send(32'hFE000EE3, 4'b0100, 8'd2,  64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    send(32'hFE000EE3, 4'b0000, 8'd3,  64'hFE000000, 64'hFFFFFFFFFE000000, 1'b0);
    send(32'h800000B7, 4'b0000, 8'd4,  64'h80000000, 64'hFFFFFFFF80000000, 1'b0);
    send(32'h800000B7, 4'b1000, 8'd5,  64'h80000000, 64'h0000000080000000, 1'b0);
    send(32'h03F09093, 4'b0101, 8'd6,  64'd31,       64'd63,               1'b0);
    send(32'h03F09093, 4'b1101, 8'd7,  64'd31,       64'd63,               1'b0);
    send(32'h000F8073, 4'b1110, 8'd8,  64'd31,       64'd31,               1'b0);
    send(32'h800000EF, 4'b0001, 8'd9,  64'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0);
    send(32'h800000EF, 4'b1001, 8'd10, 64'h00100000, 64'h0000000000100000, 1'b0);
    send(32'hFE112E23, 4'b0011, 8'd11, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    send(32'hFFFFFFFF, 4'b0111, 8'd12, 64'd0,        64'd0,                1'b1);
    send(32'h12345678, 4'b1111, 8'd13, 64'd0,        64'd0,                1'b1);
    idle(2);

    // Backpressure: two entries fill output + skid, the third is refused
    out_ready = 1'b0;
    send(32'h00100093, 4'b0010, 8'd1, 64'd1, 64'd1, 1'b0);
    send(32'h00200093, 4'b0010, 8'd2, 64'd2, 64'd2, 1'b0);
    inst = 32'h00300093; sel = 4'b0010; in_tag = 8'd3; in_valid = 1'b1;
    pend = '{e32: 64'd3, e64: 64'd3, tag: 8'd3, err: 1'b0};
    cycle(acc);
    check("bp_refused", 64'(acc), 64'd0);
    out_ready = 1'b1;
    send(32'h00300093, 4'b0010, 8'd3, 64'd3, 64'd3, 1'b0);
    idle(3);

    // Flush with both entries full, input offered in the flush cycle
    out_ready = 1'b0;
    send(32'h01000093, 4'b0010, 8'h10, 64'h10, 64'h10, 1'b0);
    send(32'h01100093, 4'b0010, 8'h11, 64'h11, 64'h11, 1'b0);
    inst = 32'h0EE00093; in_tag = 8'hEE; in_valid = 1'b1; flush = 1'b1;
    cycle(acc);
    flush = 1'b0;
    out_ready = 1'b1;
    idle(3);

    // Flush while an entry is accepted in the same cycle
    out_ready = 1'b0;
    send(32'h02000093, 4'b0010, 8'h20, 64'h20, 64'h20, 1'b0);
    inst = 32'h02100093; in_tag = 8'h21; in_valid = 1'b1; flush = 1'b1;
    cycle(acc);
    check("flush_accept_seen", 64'(acc), 64'd1);
    flush = 1'b0;
    out_ready = 1'b1;
    idle(3);

    // Asynchronous reset between clock edges
    out_ready = 1'b0;
    send(32'h03000093, 4'b0010, 8'h30, 64'h30, 64'h30, 1'b0);
    send(32'h03100093, 4'b0010, 8'h31, 64'h31, 64'h31, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid32", 64'(out_valid32), 64'd0);
    check("arst_out_valid64", 64'(out_valid64), 64'd0);
    check("arst_in_ready32",  64'(in_ready32),  64'd1);
    check("arst_in_ready64",  64'(in_ready64),  64'd1);
    check("arst_imm32",       {32'b0, out_imm32}, 64'd0);
    check("arst_imm64",       out_imm64,        64'd0);
    check("arst_tag64",       64'(out_tag64),   64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(2);

    // Random traffic against the reference model with random consumer stalls
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      ri = $urandom;
      rs = 4'($urandom_range(0, 15));
      model(ri, rs, m32, m64, me);
      send(ri, rs, 8'(k + 64), m32, m64, me);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
